// File: rtl/if_prefetch_stage.sv
// Instruction-fetch prefetch stage: issues sequential fetches, buffers in-order
// responses in a small FIFO toward decode, and handles redirects, misaligned targets and bus faults.
module if_prefetch_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_err_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc_add4_o,
    output logic [31:0] id_instruction_o,
    output logic        id_exc_addr_o,
    output logic        id_exc_fault_o
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic {S_RUN, S_HALT} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc_addr;
        logic        exc_fault;
    } entry_t;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     rsp_pc_q, rsp_pc_d;   // PC of the next kept response
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   disc_q, disc_d;
    logic            mis_q, mis_d;         // misaligned entry still to be pushed
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    entry_t          mem_q [FIFO_DEPTH];

    logic            grant, rsp_acc, rsp_keep, pop, push;
    logic [CW:0]     occ;
    entry_t          wdata, head;

    assign occ         = {1'b0, cnt_q} + {1'b0, out_q};
    assign imem_req_o  = rst_i && (state_q == S_RUN) && !redirect_i && (occ < DEPTH_L);
    assign imem_addr_o = pc_q;
    assign grant       = imem_req_o && imem_gnt_i;
    // Responses with nothing outstanding are stray and ignored.
    assign rsp_acc     = imem_rvalid_i && (out_q != '0);
    assign rsp_keep    = rsp_acc && (disc_q == '0);

    assign head             = mem_q[rptr_q];
    assign id_valid_o       = (cnt_q != '0);
    assign pop              = id_valid_o && id_ready_i;
    assign id_pc_o          = id_valid_o ? head.pc : '0;
    assign id_pc_add4_o     = id_valid_o ? head.pc + 32'd4 : '0;
    assign id_instruction_o = id_valid_o ? head.instr : '0;
    assign id_exc_addr_o    = id_valid_o && head.exc_addr;
    assign id_exc_fault_o   = id_valid_o && head.exc_fault;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        out_d    = out_q;
        disc_d   = disc_q;
        mis_d    = mis_q;
        cnt_d    = cnt_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        push     = 1'b0;
        wdata    = '0;

        if (grant) pc_d = pc_q + 32'd4;
        if (grant && !rsp_acc)      out_d = out_q + 1'b1;
        else if (!grant && rsp_acc) out_d = out_q - 1'b1;
        if (rsp_acc && disc_q != '0) disc_d = disc_q - 1'b1;

        if (rsp_keep) begin
            push            = 1'b1;
            wdata.pc        = rsp_pc_q;
            wdata.instr     = imem_err_i ? NOP : imem_rdata_i;
            wdata.exc_fault = imem_err_i;
            rsp_pc_d        = rsp_pc_q + 32'd4;
            if (imem_err_i) begin
                state_d = S_HALT;
                disc_d  = out_d;
            end
        end else if (mis_q && disc_q == '0) begin
            // Nothing can be outstanding here, so this never collides with a kept response.
            push           = 1'b1;
            wdata.pc       = rsp_pc_q;
            wdata.instr    = NOP;
            wdata.exc_addr = 1'b1;
            mis_d          = 1'b0;
        end

        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;

        if (redirect_i) begin
            push     = 1'b0;
            cnt_d    = '0;
            wptr_d   = '0;
            rptr_d   = '0;
            pc_d     = redirect_pc_i;
            rsp_pc_d = redirect_pc_i;
            out_d    = rsp_acc ? out_q - 1'b1 : out_q;
            disc_d   = out_d;
            mis_d    = |redirect_pc_i[1:0];
            state_d  = (|redirect_pc_i[1:0]) ? S_HALT : S_RUN;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_RUN;
            pc_q     <= RESET_ADDR;
            rsp_pc_q <= RESET_ADDR;
            out_q    <= '0;
            disc_q   <= '0;
            mis_q    <= 1'b0;
            cnt_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            disc_q   <= disc_d;
            mis_q    <= mis_d;
            cnt_q    <= cnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= wdata;
    end
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: in-order memory model, expected-entry scoreboard, decode-side monitor.
module tb_if_prefetch_stage;
    logic        clk_i = 1'b0, rst_i = 1'b0;
    logic        redirect_i, imem_req_o, imem_gnt_i, imem_rvalid_i, imem_err_i;
    logic [31:0] redirect_pc_i, imem_addr_o, imem_rdata_i;
    logic        id_valid_o, id_ready_i, id_exc_addr_o, id_exc_fault_o;
    logic [31:0] id_pc_o, id_pc_add4_o, id_instruction_o;

    if_prefetch_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .imem_err_i(imem_err_i),
        .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_pc_o(id_pc_o),
        .id_pc_add4_o(id_pc_add4_o), .id_instruction_o(id_instruction_o),
        .id_exc_addr_o(id_exc_addr_o), .id_exc_fault_o(id_exc_fault_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] add4;
        logic [31:0] instr;
        logic        ea;
        logic        ef;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mq[$];
    int          nvec = 0, nerr = 0, gcount = 0;
    logic        hold = 1'b0;
    logic [31:0] err_addr = 32'h1;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        nvec++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic expect_entry(input logic [31:0] pc, input logic [31:0] add4,
                                input logic [31:0] instr, input logic ea, input logic ef);
        exp_t e;
        e.pc = pc; e.add4 = add4; e.instr = instr; e.ea = ea; e.ef = ef;
        exp_q.push_back(e);
    endtask

    task automatic redirect(input logic [31:0] t);
        redirect_i    = 1'b1;
        redirect_pc_i = t;
        @(negedge clk_i);
        redirect_i    = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk_i);
        repeat (3) @(negedge clk_i);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // In-order memory: one response per cycle, at least one cycle after grant.
    always begin
        @(negedge clk_i);
        #2;
        imem_rvalid_i = 1'b0;
        imem_err_i    = 1'b0;
        imem_rdata_i  = '0;
        if (!hold && mq.size() != 0) begin
            logic [31:0] a;
            a = mq.pop_front();
            imem_rvalid_i = 1'b1;
            imem_err_i    = (a == err_addr);
            imem_rdata_i  = (a == err_addr) ? 32'hDEAD_BEEF : mdata(a);
        end
        if (imem_req_o && imem_gnt_i) begin
            mq.push_back(imem_addr_o);
            gcount++;
        end
    end

    // Decode-side monitor: every accepted head entry is checked against the scoreboard.
    always begin
        @(negedge clk_i);
        #4;
        if (id_valid_o && id_ready_i && !redirect_i) begin
            exp_t act;
            act = {id_pc_o, id_pc_add4_o, id_instruction_o, id_exc_addr_o, id_exc_fault_o};
            nvec++;
            if (exp_q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_entry: got pc=%h instr=%h ea=%b ef=%b, none expected",
                         act.pc, act.instr, act.ea, act.ef);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (act !== e) begin
                    nerr++;
                    $display("FAIL entry: got pc=%h add4=%h instr=%h ea=%b ef=%b expected pc=%h add4=%h instr=%h ea=%b ef=%b",
                             act.pc, act.add4, act.instr, act.ea, act.ef, e.pc, e.add4, e.instr, e.ea, e.ef);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        redirect_i = 1'b0; redirect_pc_i = '0; imem_gnt_i = 1'b0; id_ready_i = 1'b0;
        imem_rvalid_i = 1'b0; imem_err_i = 1'b0; imem_rdata_i = '0;
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_req", {31'b0, imem_req_o}, 0);
        chk("rst_valid", {31'b0, id_valid_o}, 0);
        chk("rst_pc", id_pc_o, 0);
        chk("rst_instr", id_instruction_o, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("post_rst_req", {31'b0, imem_req_o}, 1);
        chk("post_rst_addr", imem_addr_o, 32'h8000_0000);

        // Back-to-back sequential fetch
        @(negedge clk_i);
        expect_entry(32'h8000_0000, 32'h8000_0004, mdata(32'h8000_0000), 0, 0);
        expect_entry(32'h8000_0004, 32'h8000_0008, mdata(32'h8000_0004), 0, 0);
        expect_entry(32'h8000_0008, 32'h8000_000C, mdata(32'h8000_0008), 0, 0);
        id_ready_i = 1'b1; imem_gnt_i = 1'b1;
        repeat (3) @(negedge clk_i);
        imem_gnt_i = 1'b0;
        drain("drain_seq");

        // Backpressure: FIFO fills, one pop frees exactly one request slot
        id_ready_i = 1'b0; g0 = gcount; imem_gnt_i = 1'b1;
        repeat (10) @(negedge clk_i);
        #1;
        chk("full_grants", gcount - g0, 4);
        chk("full_req", {31'b0, imem_req_o}, 0);
        expect_entry(32'h8000_000C, 32'h8000_0010, mdata(32'h8000_000C), 0, 0);
        expect_entry(32'h8000_0010, 32'h8000_0014, mdata(32'h8000_0010), 0, 0);
        expect_entry(32'h8000_0014, 32'h8000_0018, mdata(32'h8000_0014), 0, 0);
        expect_entry(32'h8000_0018, 32'h8000_001C, mdata(32'h8000_0018), 0, 0);
        expect_entry(32'h8000_001C, 32'h8000_0020, mdata(32'h8000_001C), 0, 0);
        id_ready_i = 1'b1;
        @(negedge clk_i);
        id_ready_i = 1'b0;
        repeat (8) @(negedge clk_i);
        #1;
        chk("refill_grants", gcount - g0, 5);
        chk("refill_req", {31'b0, imem_req_o}, 0);
        imem_gnt_i = 1'b0; id_ready_i = 1'b1;
        drain("drain_full");

        // Redirect with one buffered entry and two responses in flight
        id_ready_i = 1'b0; imem_gnt_i = 1'b1;
        @(negedge clk_i);
        imem_gnt_i = 1'b0;
        repeat (3) @(negedge clk_i);
        hold = 1'b1; imem_gnt_i = 1'b1;
        repeat (2) @(negedge clk_i);
        imem_gnt_i = 1'b0;
        #1;
        chk("pre_flush_valid", {31'b0, id_valid_o}, 1);
        expect_entry(32'h0000_1000, 32'h0000_1004, mdata(32'h0000_1000), 0, 0);
        expect_entry(32'h0000_1004, 32'h0000_1008, mdata(32'h0000_1004), 0, 0);
        redirect(32'h0000_1000);
        imem_gnt_i = 1'b1;
        #1;
        chk("flush_valid", {31'b0, id_valid_o}, 0);
        chk("flush_pc", id_pc_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        imem_gnt_i = 1'b0; hold = 1'b0; id_ready_i = 1'b1;
        drain("drain_redirect");

        // Misaligned redirect target
        expect_entry(32'h0000_1002, 32'h0000_1006, 32'h0000_0013, 1, 0);
        imem_gnt_i = 1'b1; g0 = gcount;
        redirect(32'h0000_1002);
        repeat (6) @(negedge clk_i);
        #1;
        chk("misalign_grants", gcount - g0, 0);
        chk("misalign_req", {31'b0, imem_req_o}, 0);
        drain("drain_misalign");

        // Bus fault at 8000_0008
        err_addr = 32'h8000_0008;
        expect_entry(32'h8000_0000, 32'h8000_0004, mdata(32'h8000_0000), 0, 0);
        expect_entry(32'h8000_0004, 32'h8000_0008, mdata(32'h8000_0004), 0, 0);
        expect_entry(32'h8000_0008, 32'h8000_000C, 32'h0000_0013, 0, 1);
        g0 = gcount;
        redirect(32'h8000_0000);
        repeat (8) @(negedge clk_i);
        #1;
        chk("fault_grants", gcount - g0, 4);
        chk("fault_req", {31'b0, imem_req_o}, 0);
        drain("drain_fault");
        imem_gnt_i = 1'b0; err_addr = 32'h1;

        // Address wrap at the top of the address space
        expect_entry(32'hFFFF_FFF8, 32'hFFFF_FFFC, mdata(32'hFFFF_FFF8), 0, 0);
        expect_entry(32'hFFFF_FFFC, 32'h0000_0000, mdata(32'hFFFF_FFFC), 0, 0);
        expect_entry(32'h0000_0000, 32'h0000_0004, mdata(32'h0000_0000), 0, 0);
        redirect(32'hFFFF_FFF8);
        imem_gnt_i = 1'b1;
        repeat (3) @(negedge clk_i);
        imem_gnt_i = 1'b0;
        drain("drain_wrap");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
